// File: rtl/elevator_call_scheduler.sv
// LOOK-sweep elevator call scheduler: latches hall/car calls, picks the next target,
// and sequences door dwell, emergency halt and peak-hour lobby parking.
//
// state     | meaning
// IDLE      | no motion; picks serve / sweep up / sweep down / parking
// MOVE_UP   | travelling up toward lowest pending floor above
// MOVE_DN   | travelling down toward highest pending floor below
// SERVE     | stopped with door open, dwell timer running
// PARK      | peak-hour return to the home floor
// HALT      | emergency stop or invalid car position
module elevator_call_scheduler #(
    parameter int          NUM_FLOORS   = 10,
    parameter int          DWELL_CYCLES = 50,
    parameter int          PARK_CYCLES  = 200,
    parameter logic [3:0]  HOME_FLOOR   = 4'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_valid,
    input  logic [3:0]            call_floor,
    input  logic [3:0]            current_floor,
    input  logic                  weight_alert,
    input  logic                  emer_stop,
    input  logic                  peak_hour,
    output logic [3:0]            request_floor,
    output logic                  request_valid,
    output logic [1:0]            direction,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  call_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DN,
        S_SERVE,
        S_PARK,
        S_HALT
    } state_t;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int PW = $clog2(PARK_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);
    localparam logic [PW-1:0] PARK_LAST  = PW'(PARK_CYCLES - 1);
    localparam logic [4:0]    NF5        = 5'(NUM_FLOORS);

    state_t                  state_q, state_d;
    logic [3:0]              req_q, req_d;
    logic                    valid_q, valid_d;
    logic [1:0]              dir_q, dir_d;
    logic                    door_q, door_d;
    logic [NUM_FLOORS-1:0]   pend_q, pend_d;
    logic                    err_q, err_d;
    logic [DW-1:0]           dwell_q, dwell_d;
    logic [PW-1:0]           park_q, park_d;

    logic                    floor_ok, call_in_range, call_reject, call_here, call_set;
    logic                    here_pending, any_above, any_below;
    logic [3:0]              lo_above, hi_below;
    logic [NUM_FLOORS-1:0]   call_bit, cur_bit;
    logic                    go_serve, go_up, go_dn, go_idle;

    assign floor_ok      = {1'b0, current_floor} < NF5;
    assign call_in_range = {1'b0, call_floor} < NF5;
    assign call_reject   = call_valid && (!call_in_range || state_q == S_HALT);
    // A call for the floor being served only extends the dwell.
    assign call_here     = call_valid && state_q == S_SERVE && call_floor == current_floor;
    assign call_set      = call_valid && call_in_range && state_q != S_HALT && !call_here;

    always_comb begin
        call_bit = '0;
        cur_bit  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            call_bit[i] = call_set && (call_floor == 4'(i));
            cur_bit[i]  = (current_floor == 4'(i));
        end
    end

    assign here_pending = |(pend_q & cur_bit);

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        lo_above  = '0;
        hi_below  = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pend_q[i] && 4'(i) > current_floor) begin
                any_above = 1'b1;
                lo_above  = 4'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend_q[i] && 4'(i) < current_floor) begin
                any_below = 1'b1;
                hi_below  = 4'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        valid_d  = valid_q;
        dir_d    = dir_q;
        door_d   = door_q;
        dwell_d  = dwell_q;
        park_d   = '0;
        pend_d   = pend_q | call_bit;
        err_d    = call_reject;
        go_serve = 1'b0;
        go_up    = 1'b0;
        go_dn    = 1'b0;
        go_idle  = 1'b0;

        if (emer_stop || !floor_ok) begin
            state_d = S_HALT;
            valid_d = 1'b0;
            door_d  = 1'b0;
            dir_d   = DIR_IDLE;
            dwell_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (here_pending)      go_serve = 1'b1;
                    else if (any_above)    go_up    = 1'b1;
                    else if (any_below)    go_dn    = 1'b1;
                    else if (pend_q == '0 && peak_hour) begin
                        if (park_q == PARK_LAST) begin
                            if (current_floor != HOME_FLOOR) begin
                                state_d = S_PARK;
                                req_d   = HOME_FLOOR;
                                valid_d = 1'b1;
                                dir_d   = (HOME_FLOOR > current_floor) ? DIR_UP : DIR_DN;
                            end
                        end else begin
                            park_d = park_q + 1'b1;
                        end
                    end
                end
                S_MOVE_UP: begin
                    if (current_floor == req_q) go_serve = 1'b1;
                    else if (!any_above)        go_idle  = 1'b1;
                    else                        req_d    = lo_above;
                end
                S_MOVE_DN: begin
                    if (current_floor == req_q) go_serve = 1'b1;
                    else if (!any_below)        go_idle  = 1'b1;
                    else                        req_d    = hi_below;
                end
                S_SERVE: begin
                    if (call_here) begin
                        dwell_d = DWELL_LOAD;
                    end else if (weight_alert) begin
                        dwell_d = dwell_q;
                    end else if (dwell_q != '0) begin
                        dwell_d = dwell_q - 1'b1;
                    end else if (dir_q == DIR_DN) begin
                        if (any_below)      go_dn   = 1'b1;
                        else if (any_above) go_up   = 1'b1;
                        else                go_idle = 1'b1;
                    end else begin
                        if (any_above)      go_up   = 1'b1;
                        else if (any_below) go_dn   = 1'b1;
                        else                go_idle = 1'b1;
                    end
                end
                S_PARK: begin
                    if (pend_q != '0 || current_floor == HOME_FLOOR) go_idle = 1'b1;
                end
                S_HALT: begin
                    go_idle = 1'b1;
                    dwell_d = '0;
                end
                default: go_idle = 1'b1;
            endcase

            if (go_serve) begin
                state_d = S_SERVE;
                valid_d = 1'b0;
                door_d  = 1'b1;
                dwell_d = DWELL_LOAD;
                pend_d  = pend_d & ~cur_bit;
            end
            if (go_up) begin
                state_d = S_MOVE_UP;
                req_d   = lo_above;
                valid_d = 1'b1;
                dir_d   = DIR_UP;
                door_d  = 1'b0;
            end
            if (go_dn) begin
                state_d = S_MOVE_DN;
                req_d   = hi_below;
                valid_d = 1'b1;
                dir_d   = DIR_DN;
                door_d  = 1'b0;
            end
            if (go_idle) begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                dir_d   = DIR_IDLE;
                door_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            valid_q <= 1'b0;
            dir_q   <= DIR_IDLE;
            door_q  <= 1'b0;
            pend_q  <= '0;
            err_q   <= 1'b0;
            dwell_q <= '0;
            park_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            door_q  <= door_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            dwell_q <= dwell_d;
            park_q  <= park_d;
        end
    end

    assign request_floor = req_q;
    assign request_valid = valid_q;
    assign direction     = dir_q;
    assign door_open     = door_q;
    assign pending       = pend_q;
    assign call_error    = err_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: trips, pickup, reversal, overload,
// emergency halt, reset and peak-hour parking with hand-computed expectations.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       call_valid;
    logic [3:0] call_floor;
    logic [3:0] current_floor;
    logic       weight_alert;
    logic       emer_stop;
    logic       peak_hour;
    logic [3:0] request_floor;
    logic       request_valid;
    logic [1:0] direction;
    logic       door_open;
    logic [9:0] pending;
    logic       call_error;

    int checks = 0;
    int errors = 0;
    int n;
    int m;

    elevator_call_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .call_valid    (call_valid),
        .call_floor    (call_floor),
        .current_floor (current_floor),
        .weight_alert  (weight_alert),
        .emer_stop     (emer_stop),
        .peak_hour     (peak_hour),
        .request_floor (request_floor),
        .request_valid (request_valid),
        .direction     (direction),
        .door_open     (door_open),
        .pending       (pending),
        .call_error    (call_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic call(input logic [3:0] f);
        call_valid = 1'b1;
        call_floor = f;
        tick();
        call_valid = 1'b0;
    endtask

    // Counts consecutive samples with the door open, starting with the current one.
    task automatic wait_door_close(output int cnt);
        cnt = 1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (door_open) cnt++;
            else break;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; call_valid = 1'b0; call_floor = '0; current_floor = '0;
        weight_alert = 1'b0; emer_stop = 1'b0; peak_hour = 1'b0;
        tick(); tick();
        check("rst_req",   request_floor, 0);
        check("rst_valid", request_valid, 0);
        check("rst_dir",   direction, 0);
        check("rst_door",  door_open, 0);
        check("rst_pend",  pending, 0);
        check("rst_err",   call_error, 0);
        reset = 1'b0;
        tick();

        // basic trip 0 -> 5
        call(4'd5);
        check("trip_pend", pending, 10'h020);
        tick();
        check("trip_req",   request_floor, 5);
        check("trip_valid", request_valid, 1);
        check("trip_dir",   direction, 1);
        current_floor = 4'd5;
        tick();
        check("trip_door",  door_open, 1);
        check("trip_clear", pending, 0);
        check("trip_stop",  request_valid, 0);
        wait_door_close(n);
        check("trip_dwell", n, 50);
        check("trip_idle_dir", direction, 0);

        // intermediate pickup: heading to 9, call 3 at floor 1
        current_floor = 4'd0;
        call(4'd9);
        tick();
        check("pick_req9", request_floor, 9);
        current_floor = 4'd1;
        tick();
        call(4'd3);
        tick();
        check("pick_req3", request_floor, 3);
        check("pick_pend", pending, 10'h208);
        current_floor = 4'd3;
        tick();
        check("pick_door", door_open, 1);
        check("pick_pend2", pending, 10'h200);
        wait_door_close(n);
        check("pick_dwell", n, 50);
        check("pick_resume_req", request_floor, 9);
        check("pick_resume_dir", direction, 1);
        check("pick_resume_valid", request_valid, 1);
        current_floor = 4'd9;
        tick();
        wait_door_close(n);
        check("pick_end_dir", direction, 0);

        // reversal: at 5, calls 7 then 2
        current_floor = 4'd5;
        tick();
        call(4'd7);
        call(4'd2);
        check("rev_req7", request_floor, 7);
        check("rev_dir_up", direction, 1);
        current_floor = 4'd7;
        tick();
        wait_door_close(n);
        check("rev_req2", request_floor, 2);
        check("rev_dir_dn", direction, 2);
        check("rev_valid", request_valid, 1);
        current_floor = 4'd2;
        tick();
        wait_door_close(n);
        check("rev_end_dir", direction, 0);

        // overload hold then reopen at floor 3
        current_floor = 4'd3;
        tick();
        call(4'd3);
        tick();
        check("ovl_door", door_open, 1);
        n = 1;
        weight_alert = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (door_open) n++;
        end
        weight_alert = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (door_open) n++;
        end
        call(4'd3);
        check("ovl_no_pend", pending, 0);
        check("ovl_no_err", call_error, 0);
        wait_door_close(m);
        check("ovl_total_open", n + m, 91);

        // emergency halt while heading to 7 with {0,7} pending
        call(4'd7);
        call(4'd0);
        tick();
        check("emer_pend", pending, 10'h081);
        check("emer_req", request_floor, 7);
        check("emer_moving", request_valid, 1);
        emer_stop = 1'b1;
        tick();
        check("halt_valid", request_valid, 0);
        check("halt_door", door_open, 0);
        check("halt_dir", direction, 0);
        call(4'd4);
        check("halt_err", call_error, 1);
        check("halt_pend", pending, 10'h081);
        tick();
        check("halt_err_pulse", call_error, 0);
        emer_stop = 1'b0;
        tick();
        tick();
        check("resume_req", request_floor, 7);
        check("resume_valid", request_valid, 1);
        check("resume_dir", direction, 1);
        check("resume_pend", pending, 10'h081);

        // reset mid-operation
        reset = 1'b1;
        tick();
        check("midrst_pend", pending, 0);
        check("midrst_valid", request_valid, 0);
        check("midrst_dir", direction, 0);
        reset = 1'b0;
        tick();

        // peak-hour parking from floor 6
        current_floor = 4'd6;
        tick();
        peak_hour = 1'b1;
        repeat (199) tick();
        check("park_early", request_valid, 0);
        tick();
        check("park_req", request_floor, 0);
        check("park_valid", request_valid, 1);
        check("park_dir", direction, 2);
        current_floor = 4'd0;
        tick();
        check("park_arr_valid", request_valid, 0);
        check("park_arr_dir", direction, 0);
        check("park_arr_door", door_open, 0);
        repeat (5) tick();
        check("park_door_stays", door_open, 0);
        call(4'd15);
        check("bad_call_err", call_error, 1);
        check("bad_call_pend", pending, 0);
        tick();
        check("bad_call_pulse", call_error, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Collects floor calls (hall and car buttons) into a pending bitmap.
- Runs a LOOK sweep to choose the next target floor, and drives the elevator datapath's request_floor and door command.
- Sits between the button and keypad front-end and the elevator core; consumes the core's current_floor and weight alert.
- Handles door dwell, emergency halt and peak-hour lobby parking.

Parameters:
- NUM_FLOORS, 10, number of served floors (0..NUM_FLOORS-1); max 16.
- DWELL_CYCLES, 50, cycles the door is held open per stop.
- PARK_CYCLES, 200, consecutive idle cycles before parking during peak hour.
- HOME_FLOOR, 0, parking/lobby floor.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- call_valid, input, 1, one-cycle strobe; call_floor is valid.
- call_floor, input, 4, floor being called.
- current_floor, input, 4, car position from the elevator core.
- weight_alert, input, 1, overload flag from the core.
- emer_stop, input, 1, level; forces halt.
- peak_hour, input, 1, level; enables parking.
- request_floor, output, 4, target floor to the core.
- request_valid, output, 1, high while the car is commanded to move.
- direction, output, 2, 00 idle, 01 up, 10 down.
- door_open, output, 1, door command.
- pending, output, NUM_FLOORS, latched call bitmap.
- call_error, output, 1, one-cycle pulse when a call is rejected.

Behaviour:
- Reset values: all outputs 0; state IDLE; dwell and park counters 0.
- All outputs are registered. A call or current_floor change is reflected one cycle later.
- States: IDLE, MOVE_UP, MOVE_DN, SERVE, PARK, HALT.
- Call latch:
  - When call_valid is high and call_floor < NUM_FLOORS, the pending bit sets next cycle.
  - When call_floor >= NUM_FLOORS, the call is ignored and call_error pulses.
  - In HALT, calls are ignored and call_error pulses.
- Target selection (LOOK):
  - Up sweep: lowest pending floor > current_floor. Down sweep: highest pending floor < current_floor.
  - The target is recomputed every cycle in MOVE states, so a newly latched intermediate floor in the travel direction becomes the target.
- IDLE:
  - If pending[current_floor] is set: go to SERVE.
  - Else if any pending bit is above: go to MOVE_UP. Else if any is below: go to MOVE_DN. Up wins a tie.
  - request_valid and direction follow the chosen state.
- MOVE_UP / MOVE_DN:
  - When current_floor == request_floor: go to SERVE and clear that pending bit.
  - Else if no pending floor remains in the travel direction (bits cancelled only by reset), go to IDLE.
- SERVE:
  - On entry: request_valid=0, door_open=1, dwell counter loaded with DWELL_CYCLES-1.
  - The counter decrements each cycle. It holds while weight_alert is high.
  - A new call for current_floor reloads the counter and does not set the pending bit.
  - When the counter reaches 0:
    - door_open goes to 0 next cycle.
    - Continue in the same direction if a pending floor exists that way.
    - Else reverse if a pending floor exists the other way.
    - Else go to IDLE with direction=00.
- PARK:
  - Entered when the state is IDLE, pending==0 and peak_hour has been high for PARK_CYCLES consecutive cycles. The park counter resets when any of these conditions fails.
  - If current_floor == HOME_FLOOR, there is no move; the counter is cleared.
  - Otherwise request_floor=HOME_FLOOR, request_valid=1, and direction is set by comparison.
  - On arrival, go to IDLE without opening the door.
  - Any latched call aborts PARK into normal selection on the next cycle.
- HALT:
  - emer_stop high in any state goes to HALT next cycle. It overrides everything, including reset-free states mid-dwell.
  - In HALT: request_valid=0, door_open=0, direction=00. pending is retained.
  - When emer_stop falls, go to IDLE. The dwell counter is cleared and normal selection resumes from the retained bitmap.
- Reset mid-operation: returns to the reset values next cycle. pending is cleared.
- current_floor >= NUM_FLOORS is treated as a fault: go to HALT until a valid value is seen.

Test Plan:
- Basic trip:
  - Stimulus: reset, current_floor=0, call 5.
  - Required response: next cycle pending[5]=1; following cycle request_floor=5, request_valid=1, direction=01.
  - Stimulus: set current_floor=5.
  - Required response: door_open=1 for exactly 50 cycles; pending[5]=0; then IDLE, direction=00.
- Intermediate pickup:
  - Stimulus: at floor 0 heading to 9, call 3 while current_floor=1.
  - Required response: request_floor switches 9->3; stop at 3 with dwell; then request_floor=9.
- Reversal and tie:
  - Stimulus: at floor 5 idle, calls 7 and 2 in the same cycle window.
  - Required response: up first (7); after dwell, request_floor=2, direction=10.
- Overload and reopen:
  - Stimulus: during SERVE at floor 3, weight_alert high for 30 cycles; then a call for floor 3.
  - Required response: door stays open for 50+30 cycles plus a reload on the call; pending[3] never set.
- Emergency:
  - Stimulus: emer_stop mid-move to 7 with pending {7,0}.
  - Required response: request_valid=0, door_open=0 next cycle; a call for 4 during HALT pulses call_error.
  - Stimulus: release emer_stop.
  - Required response: resumes toward 7; pending retained.
- Parking:
  - Stimulus: peak_hour=1, idle at floor 6, no calls for 200 cycles.
  - Required response: request_floor=0, direction=10; on arrival door_open stays 0.
  - Stimulus: call 15.
  - Required response: call_error pulses and no pending bit is set.
